// File: rtl/data_mem_responder.sv
// -----------------------------------------------------------------------------
// data_mem_responder
//
// Memory side of the core's data load/store interface. It accepts one request
// per clock and never stalls. Writes commit at the edge that accepts them.
// Reads sample the array at the accepting edge, which gives the pre-update
// value. The result then moves through a LATENCY-deep pipeline, so read
// responses come back in issue order exactly LATENCY cycles later.
//
// Parameters:
//   ADDR_WIDTH  word-address bits; the array holds 2**ADDR_WIDTH 16-bit words
//   LATENCY     cycles from read acceptance to data_valid (1..8)
//
// Ports:
//   clk         single clock, rising-edge active
//   rst_n       synchronous active-low reset; clears the response pipeline only
//   enable      request present this cycle
//   wr          1 = write, 0 = read (ignored when enable = 0)
//   addr        byte address; the word index is addr[ADDR_WIDTH:1]
//   data_in     write data
//   data_out    read data, 16'h0000 whenever data_valid = 0
//   data_valid  data_out carries the read issued LATENCY cycles earlier
// -----------------------------------------------------------------------------
module data_mem_responder #(
    parameter int ADDR_WIDTH = 15,
    parameter int LATENCY    = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        wr,
    input  logic [15:0] addr,
    input  logic [15:0] data_in,
    output logic [15:0] data_out,
    output logic        data_valid
);

    if (LATENCY < 1 || LATENCY > 8) begin : gLatencyCheck
        $error("data_mem_responder: LATENCY must be in 1..8");
    end

    typedef struct packed {
        logic        valid;
        logic [15:0] data;
    } stageT;

    // These address bits select the word. addr[0] and any bits above
    // ADDR_WIDTH are ignored.
    localparam logic [15:0] WORD_MASK = 16'(((32'd1 << ADDR_WIDTH) - 1) << 1);

    logic [15:0]           memArray [2**ADDR_WIDTH];
    stageT                 pipe     [LATENCY];
    logic [ADDR_WIDTH-1:0] wordIdx;
    logic                  isRead;
    logic                  isWrite;
    logic                  unusedAddrBits;

    assign wordIdx        = addr[ADDR_WIDTH:1];
    assign isRead         = enable && !wr;
    assign isWrite        = enable && wr;
    assign unusedAddrBits = ^(addr & ~WORD_MASK);

    // NOTE: the array has no reset. Reset must leave its contents intact, and
    // a reset term would also stop the array from mapping onto block RAM.
    // A request seen while rst_n is low is discarded, so the write is gated.
    always_ff @(posedge clk) begin
        if (rst_n && isWrite) begin
            memArray[wordIdx] <= data_in;
        end
    end

    // Response pipeline. Stage 0 is loaded at the accepting edge. The array
    // read here sees the value from before any write at this edge, although
    // one request per cycle means a read and a write never share an edge.
    // NOTE: non-blocking assignments let every stage take its predecessor's
    // old value, so the loop order does not matter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < LATENCY; i++) begin
                pipe[i] <= '0;
            end
        end else begin
            pipe[0] <= {isRead, (isRead ? memArray[wordIdx] : 16'h0000)};
            for (int i = 1; i < LATENCY; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    // Both outputs come from registers only. Invalid stages already hold zero
    // data, and the gate keeps data_out at zero even so.
    assign data_valid = pipe[LATENCY-1].valid;
    assign data_out   = pipe[LATENCY-1].valid ? pipe[LATENCY-1].data : 16'h0000;

endmodule

// File: tb/tb_data_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_data_mem_responder
//
// Drives the same directed request stream into two responders: one with
// LATENCY = 4 and one with LATENCY = 1. A behavioural model keeps a word map
// and a table of when each response is due, keyed by edge number. One compare
// process checks both DUTs against that table on every falling edge. A
// collector records each valid response, and the directed tests pin those
// records to literal values.
// -----------------------------------------------------------------------------
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] data_in;
    logic [15:0] dataOut4;
    logic        dataValid4;
    logic [15:0] dataOut1;
    logic        dataValid1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    data_mem_responder #(.ADDR_WIDTH(15), .LATENCY(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .wr(wr), .addr(addr),
        .data_in(data_in), .data_out(dataOut4), .data_valid(dataValid4)
    );

    data_mem_responder #(.ADDR_WIDTH(15), .LATENCY(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .wr(wr), .addr(addr),
        .data_in(data_in), .data_out(dataOut1), .data_valid(dataValid1)
    );

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Every edge is numbered. A read accepted at edge k is due on the edge
    // numbered k + LATENCY - 1. The model clears any response due at or after
    // a reset edge.
    int          edgeNum = 0;
    logic [15:0] modelMem [int];
    logic [15:0] due4 [int];
    logic [15:0] due1 [int];

    always @(posedge clk) begin
        int          kill [$];
        logic [15:0] word;
        edgeNum++;
        if (!rst_n) begin
            kill = {};
            foreach (due4[k]) if (k >= edgeNum) kill.push_back(k);
            foreach (kill[j]) due4.delete(kill[j]);
            kill = {};
            foreach (due1[k]) if (k >= edgeNum) kill.push_back(k);
            foreach (kill[j]) due1.delete(kill[j]);
        end else if (enable && wr) begin
            modelMem[int'(addr) / 2] = data_in;
        end else if (enable) begin
            word = modelMem.exists(int'(addr) / 2) ? modelMem[int'(addr) / 2] : 16'h0000;
            due4[edgeNum + 3] = word;
            due1[edgeNum]     = word;
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (edgeNum > 0) begin
            check("valid L4", {15'd0, dataValid4}, {15'd0, due4.exists(edgeNum)});
            check("data L4", dataOut4, due4.exists(edgeNum) ? due4[edgeNum] : 16'h0000);
            check("valid L1", {15'd0, dataValid1}, {15'd0, due1.exists(edgeNum)});
            check("data L1", dataOut1, due1.exists(edgeNum) ? due1[edgeNum] : 16'h0000);
        end
    end

    // ---------------- response collector ----------------
    logic [15:0] got4 [$];
    logic [15:0] got1 [$];

    always @(negedge clk) begin
        if (dataValid4 === 1'b1) got4.push_back(dataOut4);
        if (dataValid1 === 1'b1) got1.push_back(dataOut1);
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic en, input logic w, input logic [15:0] a, input logic [15:0] d);
        enable  = en;
        wr      = w;
        addr    = a;
        data_in = d;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 16'h0000, 16'h0000);
    endtask

    task automatic clearGot();
        got4 = {};
        got1 = {};
    endtask

    // ---------------- directed tests ----------------
    initial begin
        rst_n   = 1'b0;
        enable  = 1'b0;
        wr      = 1'b0;
        addr    = 16'h0000;
        data_in = 16'h0000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset valid L4", {15'd0, dataValid4}, 16'h0000);
        check("reset data L4", dataOut4, 16'h0000);
        check("reset valid L1", {15'd0, dataValid1}, 16'h0000);
        rst_n = 1'b1;
        clearGot();

        // Round trip: write, then read the same word on the next cycle.
        drive(1'b1, 1'b1, 16'h0010, 16'hBEEF);
        drive(1'b1, 1'b0, 16'h0010, 16'h0000);
        idle(6);
        check("roundtrip count L4", 16'(got4.size()), 16'd1);
        if (got4.size() > 0) check("roundtrip data L4", got4[0], 16'hBEEF);
        check("roundtrip count L1", 16'(got1.size()), 16'd1);
        clearGot();

        // Streaming reads of preloaded words 0..7.
        for (int i = 0; i < 8; i++) drive(1'b1, 1'b1, 16'(2 * i), 16'(16'h1000 + i));
        for (int i = 0; i < 8; i++) drive(1'b1, 1'b0, 16'(2 * i), 16'h0000);
        idle(6);
        check("stream count L4", 16'(got4.size()), 16'd8);
        check("stream count L1", 16'(got1.size()), 16'd8);
        for (int i = 0; i < 8; i++) begin
            if (i < got4.size()) check("stream data L4", got4[i], 16'(16'h1000 + i));
        end
        clearGot();

        // Hazard ordering: a read, then a write, then a read of the same word.
        drive(1'b1, 1'b1, 16'h0020, 16'h1111);
        drive(1'b1, 1'b0, 16'h0020, 16'h0000);
        drive(1'b1, 1'b1, 16'h0020, 16'h2222);
        drive(1'b1, 1'b0, 16'h0020, 16'h0000);
        idle(6);
        check("hazard count L4", 16'(got4.size()), 16'd2);
        if (got4.size() > 1) begin
            check("hazard old L4", got4[0], 16'h1111);
            check("hazard new L4", got4[1], 16'h2222);
        end
        clearGot();

        // Byte-address aliasing, then a disabled write that must be ignored.
        drive(1'b1, 1'b1, 16'h0005, 16'hA5A5);
        drive(1'b1, 1'b0, 16'h0004, 16'h0000);
        drive(1'b0, 1'b1, 16'h0004, 16'hFFFF);
        drive(1'b1, 1'b0, 16'h0004, 16'h0000);
        idle(6);
        check("alias count L4", 16'(got4.size()), 16'd2);
        if (got4.size() > 1) begin
            check("alias data L4", got4[0], 16'hA5A5);
            check("disabled write L4", got4[1], 16'hA5A5);
        end
        clearGot();

        // Reset in flight. Reads go out at edges k and k+1. Reset lands at
        // edge k+2 with a third read presented, and that read is discarded.
        drive(1'b1, 1'b0, 16'h0010, 16'h0000);
        drive(1'b1, 1'b0, 16'h0020, 16'h0000);
        rst_n = 1'b0;
        drive(1'b1, 1'b0, 16'h0004, 16'h0000);
        rst_n = 1'b1;
        idle(6);
        check("reset drop count L4", 16'(got4.size()), 16'd0);
        check("reset drop count L1", 16'(got1.size()), 16'd2);
        if (got1.size() > 1) begin
            check("pre-reset L1 first", got1[0], 16'hBEEF);
            check("pre-reset L1 second", got1[1], 16'h2222);
        end
        clearGot();

        // The array survives reset.
        drive(1'b1, 1'b0, 16'h0010, 16'h0000);
        drive(1'b1, 1'b0, 16'h0020, 16'h0000);
        idle(6);
        check("post-reset count L4", 16'(got4.size()), 16'd2);
        if (got4.size() > 1) begin
            check("post-reset word 0x10 L4", got4[0], 16'hBEEF);
            check("post-reset word 0x20 L4", got4[1], 16'h2222);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
